iic_arbiter: RTL and testbench

IIC_ARBITER -- requirements
Module: iic_arbiter

---
 rtl/iic_pkg.sv | 15 +
 rtl/rr_select.sv | 30 +++
 rtl/iic_arbiter.sv | 133 +++++++++++++
 tb/tb_iic_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the IIC engine arbiter: FSM encoding and default timing.
package iic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int GAP_CYC_DEF     = 8;
    localparam int TIMEOUT_CYC_DEF = 1000000;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: searches upward from the requester after last winner.
module rr_select #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  win_oh,
    output logic [IDX_W-1:0] win_idx
);

    logic found;
    int   cand;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last) + i) % NREQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                win_oh[cand] = 1'b1;
                win_idx      = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/iic_arbiter.sv
// Shares one IIC send/recv engine pair among NREQ requesters with round-robin
// arbitration, per-transaction timeout and an enforced bus-idle gap.
//
// state | meaning
// IDLE  | no owner, arbitrating pending requests
// GRANT | winner chosen, fields latched onto engine outputs
// WAIT  | one engine enabled, waiting for done or timeout
// DONE  | completion pulse to owner
// GAP   | enforced bus-idle interval before next arbitration
module iic_arbiter
    import iic_pkg::*;
#(
    parameter int NREQ        = 3,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int GAP_CYC     = GAP_CYC_DEF
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic [NREQ-1:0]   I_req,
    input  logic [NREQ-1:0]   I_rw,
    input  logic [8*NREQ-1:0] I_dev_addr,
    input  logic [8*NREQ-1:0] I_word_addr,
    input  logic [2*NREQ-1:0] I_BYTE,
    input  logic [8*NREQ-1:0] I_write_date,
    output logic [NREQ-1:0]   O_gnt,
    output logic [NREQ-1:0]   O_done,
    output logic [NREQ-1:0]   O_err,
    output logic [15:0]       O_read_date,
    output logic              O_busy,
    output logic              O_recv_en,
    output logic              O_send_en,
    output logic [7:0]        O_dev_addr,
    output logic [7:0]        O_word_addr,
    output logic [7:0]        O_write_date,
    output logic [1:0]        O_BYTE,
    input  logic              I_done_flag,
    input  logic [15:0]       I_read_date
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC) + 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  last_idx, sel_idx;
    logic [NREQ-1:0]   sel_oh, win_oh, err_q;
    logic              rw_q;
    logic              timeout;

    rr_select #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req     (I_req),
        .last    (last_idx),
        .win_oh  (sel_oh),
        .win_idx (sel_idx)
    );

    assign timeout = (state == ST_WAIT) && !I_done_flag && (cnt == '0);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            last_idx     <= IDX_W'(NREQ - 1);
            win_oh       <= '0;
            err_q        <= '0;
            rw_q         <= 1'b0;
            O_dev_addr   <= '0;
            O_word_addr  <= '0;
            O_write_date <= '0;
            O_BYTE       <= '0;
            O_read_date  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err_q <= timeout ? win_oh : '0;
            // Fields are captured on the IDLE->GRANT edge so they are valid alongside O_gnt.
            if (state == ST_IDLE && |I_req) begin
                last_idx     <= sel_idx;
                win_oh       <= sel_oh;
                rw_q         <= I_rw[sel_idx];
                O_dev_addr   <= I_dev_addr[8*int'(sel_idx) +: 8];
                O_word_addr  <= I_word_addr[8*int'(sel_idx) +: 8];
                O_write_date <= I_write_date[8*int'(sel_idx) +: 8];
                O_BYTE       <= I_BYTE[2*int'(sel_idx) +: 2];
            end
            if (state == ST_WAIT && I_done_flag && rw_q) begin
                O_read_date <= I_read_date;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (|I_req) begin
                    state_nxt = ST_GRANT;
                    cnt_nxt   = CNT_W'(TIMEOUT_CYC - 1);
                end
            end
            ST_GRANT: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (I_done_flag) begin
                    state_nxt = ST_DONE;
                end else if (cnt == '0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = CNT_W'(GAP_CYC - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_GAP;
                cnt_nxt   = CNT_W'(GAP_CYC - 1);
            end
            ST_GAP: begin
                if (cnt == '0) state_nxt = ST_IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Decoded from state so an async reset removes enables without waiting for a clock.
    assign O_busy    = (state != ST_IDLE);
    assign O_gnt     = (state == ST_GRANT || state == ST_WAIT || state == ST_DONE) ? win_oh : '0;
    assign O_done    = (state == ST_DONE) ? win_oh : '0;
    assign O_err     = err_q;
    assign O_recv_en = (state == ST_WAIT) && rw_q;
    assign O_send_en = (state == ST_WAIT) && !rw_q;

endmodule

// File: tb/tb_iic_arbiter.sv
// Directed bench for iic_arbiter with a completion scoreboard queue.
module tb_iic_arbiter;

    localparam int NREQ = 3;
    localparam int TOC  = 100;
    localparam int GAP  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req, rw;
    logic [8*NREQ-1:0] dev_addr, word_addr, write_date;
    logic [2*NREQ-1:0] byte_cnt;
    logic [NREQ-1:0]   gnt, done, err;
    logic [15:0]       read_date, rd_in;
    logic              busy, recv_en, send_en, done_flag;
    logic [7:0]        o_dev, o_word, o_wdat;
    logic [1:0]        o_byte;

    typedef struct {
        logic [NREQ-1:0] done_v;
        logic [NREQ-1:0] err_v;
        logic [15:0]     rd;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    iic_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TOC), .GAP_CYC(GAP)) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_req(req), .I_rw(rw),
        .I_dev_addr(dev_addr), .I_word_addr(word_addr), .I_BYTE(byte_cnt),
        .I_write_date(write_date), .O_gnt(gnt), .O_done(done), .O_err(err),
        .O_read_date(read_date), .O_busy(busy), .O_recv_en(recv_en),
        .O_send_en(send_en), .O_dev_addr(o_dev), .O_word_addr(o_word),
        .O_write_date(o_wdat), .O_BYTE(o_byte), .I_done_flag(done_flag),
        .I_read_date(rd_in)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_done(input logic [15:0] data);
        done_flag = 1'b1;
        rd_in     = data;
        @(negedge clk);
        done_flag = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        exp_t e;
        n = 0;
        while (!(|done || |err) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("resp_wait", n < 300, 1);
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("resp_done", done, e.done_v);
            chk("resp_err", err, e.err_v);
            chk("resp_read_date", read_date, e.rd);
        end
    endtask

    task automatic wait_en(output int n);
        n = 0;
        while (!(recv_en || send_en) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("enable_wait", n < 300, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", n < 300, 1);
    endtask

    initial begin
        int   n;
        logic send_seen;
        rst_n = 1'b0; req = '0; rw = '0; dev_addr = '0; word_addr = '0;
        write_date = '0; byte_cnt = '0; done_flag = 1'b0; rd_in = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enables", {recv_en, send_en}, 0);
        chk("rst_fields", {o_dev, o_word, o_wdat, o_byte, read_date}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single read from requester 0
        rw = 3'b001; dev_addr[7:0] = 8'hD6; word_addr[7:0] = 8'h1E; byte_cnt[1:0] = 2'd2;
        req = 3'b001;
        sbq.push_back('{3'b001, 3'b000, 16'h0840});
        @(negedge clk);
        chk("rd_gnt_n1", gnt, 3'b001);
        chk("rd_busy", busy, 1);
        chk("rd_en_n1", recv_en, 0);
        @(negedge clk);
        chk("rd_recv_n2", recv_en, 1);
        chk("rd_dev", o_dev, 8'hD6);
        chk("rd_word", o_word, 8'h1E);
        chk("rd_byte", o_byte, 2'd2);
        send_seen = send_en;
        repeat (3) begin
            @(negedge clk);
            send_seen = send_seen | send_en;
        end
        pulse_done(16'h0840);
        wait_resp(n);
        chk("rd_done_latency", n, 0);
        chk("rd_en_in_done", recv_en, 0);
        chk("rd_gnt_in_done", gnt, 3'b001);
        chk("rd_send_never", send_seen, 0);
        req = '0;

        // stray done flag in GAP and IDLE
        @(negedge clk);
        pulse_done(16'hBEEF);
        chk("gap_stray_done", done, 0);
        chk("gap_stray_busy", busy, 1);
        wait_idle();
        pulse_done(16'hBEEF);
        chk("idle_stray_done", done, 0);
        chk("idle_stray_busy", busy, 0);
        chk("stray_read_date", read_date, 16'h0840);

        // write from requester 2
        rw = 3'b000; dev_addr[23:16] = 8'hD6; word_addr[23:16] = 8'h00; write_date[23:16] = 8'hA5;
        req = 3'b100;
        sbq.push_back('{3'b100, 3'b000, 16'h0840});
        wait_en(n);
        chk("wr_gnt", gnt, 3'b100);
        chk("wr_send", send_en, 1);
        chk("wr_recv", recv_en, 0);
        chk("wr_wdat", o_wdat, 8'hA5);
        chk("wr_dev", o_dev, 8'hD6);
        pulse_done(16'hFFFF);
        wait_resp(n);
        req = '0;
        wait_idle();

        // contention: all three held, order 0,1,2,0
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_en(n);
            chk("rr_onehot", $onehot(gnt), 1);
            chk("rr_order", gnt, 3'b001 << (k % 3));
            if (k > 0) chk("rr_gap_ok", n >= GAP, 1);
            sbq.push_back('{3'b001 << (k % 3), 3'b000, 16'h0840});
            pulse_done(16'h1111);
            wait_resp(n);
        end
        req = '0;
        wait_idle();

        // timeout on requester 1 (read)
        rw = 3'b010; req = 3'b010;
        wait_en(n);
        chk("to_gnt", gnt, 3'b010);
        sbq.push_back('{3'b000, 3'b010, 16'h0840});
        n = 0;
        while (recv_en && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to_wait_cycles", n, TOC);
        chk("to_gnt_cleared", gnt, 0);
        wait_resp(n);
        chk("to_err_latency", n, 0);
        req = '0;
        @(negedge clk);
        chk("to_err_one_cycle", err, 0);
        wait_idle();

        // reset in WAIT cycle 5
        rw = 3'b001; req = 3'b001;
        wait_en(n);
        chk("rst_mid_gnt", gnt, 3'b001);
        repeat (4) @(negedge clk);
        chk("rst_mid_recv_before", recv_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_recv", recv_en, 0);
        chk("rst_mid_outs", {gnt, done, err, busy, send_en}, 0);
        chk("rst_mid_fields", {o_dev, o_word, read_date}, 0);
        @(negedge clk);
        chk("rst_mid_no_pulse", {done, err}, 0);
        req = 3'b010; rw = 3'b010; rst_n = 1'b1;
        wait_en(n);
        chk("post_rst_gnt", gnt, 3'b010);
        sbq.push_back('{3'b010, 3'b000, 16'h1234});
        pulse_done(16'h1234);
        wait_resp(n);
        req = '0;
        wait_idle();
        chk("sb_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
